// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, state tags, packet structs and requantizer for the CNN processing element
package cnn_pkg;
  localparam int LANES     = 4;
  localparam int DW        = 8;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int ACC_W     = 24;
  localparam int OUT_SHIFT = 8;
  localparam int PW        = 2 * DW + 1;

  typedef enum logic [2:0] {
    INVALID = 3'd0,
    VALID   = 3'd1,
    CNN_FIN = 3'd2
  } PE_STATE;

  // State tag is kept as raw 3 bits so undefined codes travel through unchanged
  typedef struct packed {
    logic [2:0]               PE_state;
    logic [LANES-1:0][DW-1:0] A;
    logic [DW-1:0]            wrb_data;
    logic [AW-1:0]            wrb_addr;
    logic [LANES-1:0]         wrb;
    logic [AW-1:0]            rdb_addr;
  } PE_IN_PACKET;

  typedef struct packed {
    logic [2:0]    PE_state;
    logic [DW-1:0] data;
  } PE_OUT_PACKET;

  // Arithmetic shift down, then clamp negatives to 0 and large values to all-ones
  function automatic logic [DW-1:0] requant(input logic [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = $signed(v) >>> OUT_SHIFT;
    return s[ACC_W-1] ? '0 : |s[ACC_W-2:DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction
endpackage

// File: rtl/pe_weight_bank.sv
// pe_weight_bank: per-lane weight register file, one write port and one registered read-first port
module pe_weight_bank
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [DW-1:0]            rd_q, rd_d;

  // Write updates one entry; the read samples pre-write contents so a same-address access returns old data
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
    rd_d = mem_q[rd_addr];
  end

  // Storage and read register, cleared by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end

  assign rd_data = rd_q;
endmodule

// File: rtl/cnn_pe.sv
// cnn_pe: 4-lane multiply-accumulate processing element with requantized 8-bit output
module cnn_pe
  import cnn_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  PE_IN_PACKET  pe_in_pk,
  output PE_OUT_PACKET pe_out_pk
);
  logic [LANES-1:0][DW-1:0] w;
  logic [LANES-1:0][DW-1:0] a1_q, a1_d;
  logic [LANES-1:0][PW-1:0] p_q, p_d;
  logic [2:0]               st1_q, st1_d, st2_q, st2_d, st3_q, st3_d;
  logic [ACC_W-1:0]         acc_q, acc_d, sum, tot;
  logic [DW-1:0]            data_q, data_d;

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    pe_weight_bank u_bank (
      .clk    (clk),
      .rst_n  (reset),
      .we     (pe_in_pk.wrb[k]),
      .wr_addr(pe_in_pk.wrb_addr),
      .wr_data(pe_in_pk.wrb_data),
      .rd_addr(pe_in_pk.rdb_addr),
      .rd_data(w[k])
    );
  end

  // S1 captures activations and tag alongside the bank read; S2 forms unsigned-by-signed lane products
  always_comb begin
    a1_d  = pe_in_pk.A;
    st1_d = pe_in_pk.PE_state;
    st2_d = st1_q;
    for (int i = 0; i < LANES; i++)
      p_d[i] = $signed({{(PW-DW){1'b0}}, a1_q[i]}) * $signed({{(PW-DW){w[i][DW-1]}}, w[i]});
  end

  // S3 sums the products, accumulates on VALID, and on CNN_FIN emits the requantized total and clears
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + {{(ACC_W-PW){p_q[i][PW-1]}}, p_q[i]};
    tot    = acc_q + sum;
    st3_d  = st2_q;
    acc_d  = st2_q == VALID ? tot : st2_q == CNN_FIN ? '0 : acc_q;
    data_d = st2_q == CNN_FIN ? requant(tot) : data_q;
  end

  // Pipeline, accumulator and output registers; reset drops any partial sum
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a1_q   <= '0;
      p_q    <= '0;
      st1_q  <= INVALID;
      st2_q  <= INVALID;
      st3_q  <= INVALID;
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      a1_q   <= a1_d;
      p_q    <= p_d;
      st1_q  <= st1_d;
      st2_q  <= st2_d;
      st3_q  <= st3_d;
      acc_q  <= acc_d;
      data_q <= data_d;
    end

  assign pe_out_pk.PE_state = st3_q;
  assign pe_out_pk.data     = data_q;
endmodule

// File: tb/tb_cnn_pe.sv
// tb_cnn_pe: scoreboard plus table-driven checks for the cnn_pe processing element
module tb_cnn_pe;
  import cnn_pkg::*;

  typedef struct {
    logic [2:0] st;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [LANES-1:0][DW-1:0] a;
    logic [7:0]               w;
    int                       exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  PE_IN_PACKET  pin;
  PE_OUT_PACKET pout;
  int           n_vec = 0;
  int           n_err = 0;
  int           wm [LANES][DEPTH];
  int           acc_m = 0;
  int           data_m = 0;
  exp_t         q [$];
  vec_t         tv [11];

  cnn_pe dut (
    .clk      (clk),
    .reset    (reset),
    .pe_in_pk (pin),
    .pe_out_pk(pout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    int s;
    s = v >>> 8;
    return s < 0 ? 0 : s > 255 ? 255 : s;
  endfunction

  task automatic step(input logic [2:0] st, input logic [LANES-1:0][DW-1:0] a, input int raddr,
                      input logic [3:0] wrb, input int waddr, input logic [7:0] wdata);
    int   sum;
    exp_t e;
    sum = 0;
    pin.PE_state = st;
    pin.A        = a;
    pin.rdb_addr = raddr[3:0];
    pin.wrb      = wrb;
    pin.wrb_addr = waddr[3:0];
    pin.wrb_data = wdata;
    for (int k = 0; k < LANES; k++) sum += int'(a[k]) * wm[k][raddr];
    if (st == VALID) acc_m += sum;
    else if (st == CNN_FIN) begin
      data_m = sat(acc_m + sum);
      acc_m  = 0;
    end
    q.push_back('{st, data_m[7:0]});
    for (int k = 0; k < LANES; k++) if (wrb[k]) wm[k][waddr] = int'($signed(wdata));
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("sb_state", int'(pout.PE_state), int'(e.st));
      chk("sb_data", int'(pout.data), int'(e.data));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(INVALID, '0, 0, 4'b0, 0, 8'h0);
  endtask

  task automatic load(input logic [3:0] wrb, input int addr, input logic [7:0] data);
    step(INVALID, '0, 0, wrb, addr, data);
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    #1;
    chk("rst_state", int'(pout.PE_state), 0);
    chk("rst_data", int'(pout.data), 0);
    acc_m  = 0;
    data_m = 0;
    q.delete();
    foreach (wm[k, j]) wm[k][j] = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic window9(input int n);
    logic [LANES-1:0][DW-1:0] a;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < LANES; k++) a[k] = DW'(16 * k + i);
      step(i < 8 ? VALID : CNN_FIN, a, i, 4'b0, 0, 8'h0);
    end
  endtask

  task automatic load9();
    for (int i = 0; i < 9; i++) load(4'hF, i, 8'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{{4{8'd16}},  8'd16,  4};
    tv[1]  = '{{4{8'd255}}, 8'd65,  255};
    tv[2]  = '{{4{8'd255}}, 8'h80,  0};
    tv[3]  = '{{8'd0, 8'd0, 8'd0, 8'd100}, 8'd3, 1};
    tv[4]  = '{{4{8'd0}},   8'd127, 0};
    tv[5]  = '{{8'd0, 8'd0, 8'd128, 8'd128}, 8'd2, 2};
    tv[6]  = '{{4{8'd64}},  8'hFF,  0};
    tv[7]  = '{{4{8'd200}}, 8'd80,  250};
    tv[8]  = '{{4{8'd255}}, 8'd64,  255};
    tv[9]  = '{{4{8'd200}}, 8'd81,  253};
    tv[10] = '{{4{8'd255}}, 8'd127, 255};
    pin = '0;
    #2 hard_reset();
    load9();
    window9(9);
    window9(9);
    idle(1);
    chk("fin_minus1_state", int'(pout.PE_state), int'(VALID));
    idle(1);
    chk("fin_lat3_state", int'(pout.PE_state), int'(CNN_FIN));
    chk("window_data", int'(pout.data), 20);
    window9(4);
    pin.PE_state = VALID;
    pin.rdb_addr = 4'd4;
    pin.wrb      = 4'b0;
    hard_reset();
    window9(9);
    idle(3);
    chk("cleared_w_data", int'(pout.data), 0);
    load9();
    window9(9);
    idle(3);
    chk("reload_data", int'(pout.data), 20);
    load(4'b0001, 10, 8'hFF);
    for (int i = 0; i < 4; i++)
      step(i < 3 ? VALID : CNN_FIN, {8'd50, 8'd50, 8'd50, 8'd200}, 10, 4'b0, 0, 8'h0);
    idle(3);
    chk("relu_data", int'(pout.data), 0);
    for (int i = 0; i < 16; i++) load(4'hF, i, 8'd127);
    for (int i = 0; i < 16; i++)
      step(i < 15 ? VALID : CNN_FIN, {4{8'd255}}, i, 4'b0, 0, 8'h0);
    idle(3);
    chk("sat_data", int'(pout.data), 255);
    step(VALID, {4{8'd10}}, 3, 4'b0100, 3, 8'h9C);
    step(CNN_FIN, {4{8'd10}}, 3, 4'b0, 0, 8'h0);
    idle(3);
    chk("read_first_data", int'(pout.data), 30);
    for (int i = 0; i < 11; i++) begin
      load(4'hF, 15, tv[i].w);
      step(CNN_FIN, tv[i].a, 15, 4'b0, 0, 8'h0);
      idle(3);
      chk($sformatf("table%0d_data", i), int'(pout.data), tv[i].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
